aes_round_seq: RTL and testbench

Sequencer for AES-128 encryption that sits upstream and downstream of the round-transform stage. It performs the initial AddRoundKey on the accepted plaintext, then drives the round-transform stage once per round. After each round it XORs the returned block with the round key. After the last round it presents the ciphertext on a valid/ready output. Round keys come from an external key-schedule table, indexed by this block.

---
 rtl/aes_round_seq_if.sv | 32 +++
 rtl/aes_round_seq.sv | 106 ++++++++++
 tb/tb_aes_round_seq.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_seq_if.sv
// Plaintext-in / ciphertext-out stream bundle for aes_round_seq.
//   in_valid_i, in_ready_o, in_data_i    : plaintext valid/ready handshake
//   out_valid_o, out_ready_i, out_data_o : ciphertext valid/ready handshake
// Modports:
//   slave  : the sequencer side (consumes plaintext, produces ciphertext)
//   master : the environment side (produces plaintext, consumes ciphertext)
interface aes_round_seq_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/aes_round_seq.sv
// AES-128 encryption sequencer wrapped around an external round-transform stage.
// Applies the initial AddRoundKey to the accepted plaintext, starts the round
// transform once per round, XORs each returned block with the next round key and
// presents the ciphertext after round NR.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   flush_i               : synchronous abort back to IDLE
//   io (slave)            : plaintext in / ciphertext out valid-ready streams
//   rk_idx_o, rk_i        : round-key table index and the key it returns (same cycle)
//   rt_start_o, rt_b_o    : start pulse and block to the round transform
//   rt_b_mc_i, rt_b_sr_i  : round-transform results after MixColumns / ShiftRows
//   rt_done_i             : round-transform results valid this cycle
//   busy_o                : high whenever not IDLE
module aes_round_seq #(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4    // 2**RW must exceed NR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    aes_round_seq_if.slave        io,
    output logic [RW-1:0]         rk_idx_o,
    input  logic [127:0]          rk_i,
    output logic                  rt_start_o,
    output logic [127:0]          rt_b_o,
    input  logic [127:0]          rt_b_mc_i,
    input  logic [127:0]          rt_b_sr_i,
    input  logic                  rt_done_i,
    output logic                  busy_o
);

    localparam logic [RW-1:0] NrW = RW'(NR);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StOut} state_e;

    state_e        state_q, state_d;
    logic [127:0]  blk_q, blk_d;
    logic [RW-1:0] round_q, round_d;
    logic [127:0]  res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            blk_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        round_d = round_q;
        res     = rt_b_mc_i;
        if (flush_i) begin
            // Abort wins over every transition, including an accept in IDLE.
            state_d = StIdle;
            round_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (io.in_valid_i) begin
                        blk_d   = io.in_data_i ^ rk_i;
                        round_d = RW'(1);
                        state_d = StStart;
                    end
                end
                StStart: state_d = StWait;
                StWait: begin
                    if (rt_done_i) begin
                        // Last round skips MixColumns.
                        res   = (round_q == NrW) ? rt_b_sr_i : rt_b_mc_i;
                        blk_d = res ^ rk_i;
                        if (round_q == NrW) begin
                            state_d = StOut;
                        end else begin
                            round_d = round_q + RW'(1);
                            state_d = StStart;
                        end
                    end
                end
                StOut: begin
                    if (io.out_ready_i) begin
                        // Clearing round keeps rk_idx_o at 0 throughout IDLE.
                        round_d = '0;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // in_ready_o is gated by rst_n so it stays low while reset is held.
    assign io.in_ready_o  = (state_q == StIdle) && rst_n;
    assign io.out_valid_o = (state_q == StOut);
    assign io.out_data_o  = blk_q;
    assign rt_start_o     = (state_q == StStart) && !flush_i;
    assign rt_b_o         = blk_q;
    assign rk_idx_o       = round_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_aes_round_seq.sv
// Self-checking bench for aes_round_seq: models the round transform (SubBytes,
// ShiftRows, MixColumns) with a per-round latency table and an AES-128 key
// schedule feeding the round-key table; compares against FIPS-197 ciphertexts.
module tb_aes_round_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         rt_start;
    logic [127:0] rt_b;
    logic [127:0] rt_mc;
    logic [127:0] rt_sr;
    logic         rt_done;
    logic         busy;

    aes_round_seq_if bus ();

    aes_round_seq #(.NR(10), .RW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush),
        .io        (bus),
        .rk_idx_o  (rk_idx),
        .rk_i      (rk),
        .rt_start_o(rt_start),
        .rt_b_o    (rt_b),
        .rt_b_mc_i (rt_mc),
        .rt_b_sr_i (rt_sr),
        .rt_done_i (rt_done),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk_tab [0:15];
    int           lat_tab [0:15];

    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CtZ   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    assign rk = rk_tab[rk_idx];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_sbox;
        logic [7:0] y, inv;
        for (int x = 0; x < 256; x++) begin
            // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
            y   = 8'(x);
            inv = 8'h01;
            for (int k = 1; k < 8; k++) begin
                y   = gmul(y, y);
                inv = gmul(inv, y);
            end
            if (x == 0) inv = 8'h00;
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]],
                     sbox_tab[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rk_tab[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    task automatic rt_model(input logic [127:0] b, output logic [127:0] sr,
                            output logic [127:0] mc);
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(r+4*c) -: 8] = sbox_tab[b[127-8*(r+4*((c+r)%4)) -: 8]];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
    endtask

    // Round-transform model: latches rt_b at the start pulse and raises rt_done
    // lat_tab[round] cycles later, driven on the falling edge.
    initial begin
        int           cnt;
        logic [127:0] m_blk;
        logic [127:0] s, m;
        cnt     = 0;
        rt_done = 1'b0;
        rt_sr   = '0;
        rt_mc   = '0;
        forever begin
            @(negedge clk);
            rt_done = 1'b0;
            if (cnt != 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    rt_model(m_blk, s, m);
                    rt_sr   = s;
                    rt_mc   = m;
                    rt_done = 1'b1;
                end
            end else if (rt_start === 1'b1) begin
                m_blk = rt_b;
                cnt   = lat_tab[rk_idx];
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic set_lat(input bit rand_lat);
        for (int r = 0; r < 16; r++) lat_tab[r] = 1;
        if (rand_lat) begin
            for (int r = 1; r <= 10; r++) lat_tab[r] = int'($urandom_range(8, 1));
        end
    endtask

    // Accepts one plaintext and follows it to the OUT state, checking ciphertext,
    // start-pulse count, key-index sequence and latency.
    task automatic run_vector(input logic [127:0] key, input logic [127:0] pt,
                              input logic [127:0] ct, input bit rand_lat,
                              input string name);
        int cyc, starts, nd, exp_cyc, n;
        bit seq_ok;
        load_key(key);
        set_lat(rand_lat);
        exp_cyc = 1;
        for (int r = 1; r <= 10; r++) exp_cyc += lat_tab[r] + 1;
        bus.in_data_i  = pt;
        bus.in_valid_i = 1'b1;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        checks++;
        if (bus.in_ready_o !== 1'b1 || rk_idx !== 4'd0) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b rk_idx=%0d, need 1 and 0",
                     name, bus.in_ready_o, rk_idx);
        end
        tick;
        bus.in_valid_i = 1'b0;
        cyc    = 1;
        starts = 0;
        nd     = 0;
        seq_ok = 1'b1;
        while (bus.out_valid_o !== 1'b1 && cyc < 500) begin
            if (rt_start === 1'b1) starts++;
            if (rt_done === 1'b1) begin
                nd++;
                if (rk_idx !== 4'(nd)) seq_ok = 1'b0;
            end
            tick;
            cyc++;
        end
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== ct) begin
            errors++;
            $display("FAIL %s data: valid=%b got %h, need %h", name,
                     bus.out_valid_o, bus.out_data_o, ct);
        end
        checks++;
        if (starts != 10) begin
            errors++;
            $display("FAIL %s starts: got %0d, need 10", name, starts);
        end
        checks++;
        if (nd != 10 || !seq_ok) begin
            errors++;
            $display("FAIL %s rk_idx sequence: done count %0d in-order=%0d, need 10 and 1",
                     name, nd, seq_ok);
        end
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, need %0d", name, cyc, exp_cyc);
        end
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b0 || busy !== 1'b0 ||
            rt_start !== 1'b0 || rk_idx !== 4'd0 || rt_b !== 128'h0) begin
            errors++;
            $display("FAIL reset outputs: in_ready=%b out_valid=%b busy=%b start=%b rk_idx=%0d rt_b=%h, need all 0",
                     bus.in_ready_o, bus.out_valid_o, busy, rt_start, rk_idx, rt_b);
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (bus.in_ready_o !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset release: in_ready=%b busy=%b, need 1 and 0",
                     bus.in_ready_o, busy);
        end
    endtask

    task automatic test_fips_c1;
        run_vector(KeyC1, PtC1, CtC1, 1'b0, "c1_l1");
    endtask

    task automatic test_random_latency;
        run_vector(KeyC1, PtC1, CtC1, 1'b1, "c1_rand");
        run_vector(KeyB, PtB, CtB, 1'b1, "b_rand");
    endtask

    task automatic test_out_stall;
        bus.out_ready_i = 1'b0;
        run_vector(KeyC1, PtC1, CtC1, 1'b0, "stall");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== CtC1 ||
                bus.in_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall hold %0d: valid=%b data=%h in_ready=%b, need 1 %h 0",
                         i, bus.out_valid_o, bus.out_data_o, bus.in_ready_o, CtC1);
            end
            tick;
        end
        bus.out_ready_i = 1'b1;
        checks++;
        if (bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stall handshake cycle: in_ready=%b, need 0", bus.in_ready_o);
        end
        tick;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall release: valid=%b in_ready=%b, need 0 and 1",
                     bus.out_valid_o, bus.in_ready_o);
        end
    endtask

    task automatic test_flush;
        int n, starts, valids;
        load_key(KeyC1);
        set_lat(1'b0);
        lat_tab[4] = 2;
        bus.in_data_i  = PtC1;
        bus.in_valid_i = 1'b1;
        tick;
        bus.in_valid_i = 1'b0;
        n = 0;
        while (!(rt_start === 1'b1 && rk_idx == 4'd4) && n < 300) begin
            tick;
            n++;
        end
        checks++;
        if (rt_start !== 1'b1 || rk_idx !== 4'd4) begin
            errors++;
            $display("FAIL flush reach round 4: start=%b rk_idx=%0d, need 1 and 4",
                     rt_start, rk_idx);
        end
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.out_valid_o !== 1'b0 || rk_idx !== 4'd0 ||
            bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush idle: busy=%b valid=%b rk_idx=%0d in_ready=%b, need 0 0 0 1",
                     busy, bus.out_valid_o, rk_idx, bus.in_ready_o);
        end
        starts = 0;
        valids = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (rt_start === 1'b1) starts++;
            if (bus.out_valid_o === 1'b1 || busy === 1'b1) valids++;
        end
        checks++;
        if (starts != 0 || valids != 0) begin
            errors++;
            $display("FAIL flush quiet: starts=%0d busy/valid cycles=%0d, need 0 and 0",
                     starts, valids);
        end
        run_vector(KeyC1, PtC1, CtC1, 1'b0, "after_flush");
    endtask

    task automatic test_reset_mid;
        int n;
        load_key(KeyC1);
        set_lat(1'b0);
        bus.in_data_i  = PtC1;
        bus.in_valid_i = 1'b1;
        tick;
        bus.in_valid_i = 1'b0;
        n = 0;
        while (!(rt_start === 1'b1 && rk_idx == 4'd7) && n < 300) begin
            tick;
            n++;
        end
        tick;
        checks++;
        if (busy !== 1'b1 || rk_idx !== 4'd7) begin
            errors++;
            $display("FAIL midreset reach round 7: busy=%b rk_idx=%0d, need 1 and 7",
                     busy, rk_idx);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || bus.out_valid_o !== 1'b0 || rt_start !== 1'b0 ||
            rk_idx !== 4'd0 || rt_b !== 128'h0 || bus.out_data_o !== 128'h0 ||
            bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs: busy=%b valid=%b start=%b rk_idx=%0d rt_b=%h in_ready=%b, need all 0",
                     busy, bus.out_valid_o, rt_start, rk_idx, rt_b, bus.in_ready_o);
        end
        rst_n = 1'b1;
        tick;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset release: in_ready=%b, need 1", bus.in_ready_o);
        end
        repeat (5) tick;
    endtask

    task automatic test_back_to_back;
        logic [127:0] keys [0:2];
        logic [127:0] pts  [0:2];
        logic [127:0] cts  [0:2];
        int n, g;
        keys[0] = KeyC1; pts[0] = PtC1;   cts[0] = CtC1;
        keys[1] = KeyB;  pts[1] = PtB;    cts[1] = CtB;
        keys[2] = '0;    pts[2] = '0;     cts[2] = CtZ;
        set_lat(1'b0);
        load_key(keys[0]);
        bus.in_data_i   = pts[0];
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        for (int v = 0; v < 3; v++) begin
            if (v > 0) begin
                g = 0;
                do begin
                    tick;
                    g++;
                end while (bus.in_ready_o !== 1'b1 && g < 50);
                checks++;
                if (g != 1) begin
                    errors++;
                    $display("FAIL b2b gap %0d: %0d cycles out_valid to accept, need 1", v, g);
                end
            end
            tick;
            n = 0;
            while (bus.out_valid_o !== 1'b1 && n < 100) begin
                tick;
                n++;
            end
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== cts[v]) begin
                errors++;
                $display("FAIL b2b vector %0d: valid=%b got %h, need %h", v,
                         bus.out_valid_o, bus.out_data_o, cts[v]);
            end
            if (v < 2) begin
                load_key(keys[v+1]);
                bus.in_data_i = pts[v+1];
            end
        end
        bus.in_valid_i = 1'b0;
        tick;
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;
        init_sbox;
        set_lat(1'b0);
        load_key('0);
        test_reset;
        test_fips_c1;
        test_random_latency;
        test_out_stall;
        test_flush;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
